// File: rtl/ksa_share_arbiter_pkg.sv
// Shared types and helpers for the Kogge-Stone adder share arbiter.
// Holds operand/sum widths, the arbiter state enum and the round-robin picker.
package ksa_share_pkg;

    localparam int unsigned XW     = 8;
    localparam int unsigned YW     = 10;
    localparam int unsigned SW     = 11;
    localparam int unsigned MaxReq = 8;
    localparam int unsigned MaxIdw = 3;

    typedef enum logic {
        StArb,
        StLock
    } state_e;

    typedef struct packed {
        logic              found;
        logic [MaxIdw-1:0] idx;
    } pick_t;

    // First valid index scanning ptr, ptr+1, ... modulo nreq.
    function automatic pick_t rr_pick(input logic [MaxReq-1:0] valid,
                                      input logic [MaxIdw-1:0] ptr,
                                      input int unsigned       nreq);
        pick_t       pick;
        int unsigned cand;
        pick = '0;
        for (int unsigned off = 0; off < MaxReq; off++) begin
            cand = (32'(ptr) + off) % nreq;
            if (off < nreq && !pick.found && valid[cand[MaxIdw-1:0]]) begin
                pick.found = 1'b1;
                pick.idx   = cand[MaxIdw-1:0];
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/ksa_share_arbiter_if.sv
// Requester and result bundle between client engines and the shared adder arbiter.
// master = client side, slave = arbiter side.
interface ksa_share_arbiter_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
);

    logic [NREQ-1:0]                    req_valid;
    logic [NREQ-1:0]                    req_lock;
    logic [NREQ*ksa_share_pkg::XW-1:0]  req_x;
    logic [NREQ*ksa_share_pkg::YW-1:0]  req_y;
    logic [NREQ-1:0]                    req_ready;
    logic                               res_valid;
    logic                               res_ready;
    logic [ksa_share_pkg::SW-1:0]       res_s;
    logic [IDW-1:0]                     res_id;
    logic                               busy;

    modport master (
        output req_valid, req_lock, req_x, req_y, res_ready,
        input  req_ready, res_valid, res_s, res_id, busy
    );

    modport slave (
        input  req_valid, req_lock, req_x, req_y, res_ready,
        output req_ready, res_valid, res_s, res_id, busy
    );

endinterface

// File: rtl/ksa_share_arbiter_adder.sv
// Combinational Kogge-Stone adder, 8-bit X plus 10-bit Y, carry-in 0, 11-bit sum.
// Prefix levels use full-width shifts; shifted-in zeros make the low bits pass through.
module UBKSA_7_0_9_0 (
    input  logic [7:0]  x_i,
    input  logic [9:0]  y_i,
    output logic [10:0] s_o
);

    logic [9:0] a;
    logic [9:0] g0, g1, g2, g3, g4;
    logic [9:0] p0, p1, p2, p3;

    always_comb begin
        a  = {2'b00, x_i};
        g0 = a & y_i;
        p0 = a ^ y_i;
        g1 = g0 | (p0 & (g0 << 1));
        p1 = p0 & (p0 << 1);
        g2 = g1 | (p1 & (g1 << 2));
        p2 = p1 & (p1 << 2);
        g3 = g2 | (p2 & (g2 << 4));
        p3 = p2 & (p2 << 4);
        g4 = g3 | (p3 & (g3 << 8));
        s_o = {g4[9], p0 ^ {g4[8:0], 1'b0}};
    end

endmodule

// File: rtl/ksa_share_arbiter.sv
// Round-robin arbiter with optional lock sharing one Kogge-Stone adder among NREQ clients.
// The sum is registered once and tagged with the winning requester index.
module ksa_share_arbiter
    import ksa_share_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    ksa_share_arbiter_if.slave  bus
);

    state_e          state_q;
    logic [IDW-1:0]  ptr_q;
    logic [IDW-1:0]  owner_q;
    logic [IDW-1:0]  res_id_q;
    logic [SW-1:0]   res_s_q;
    logic            res_valid_q;

    pick_t           pick;
    logic [IDW-1:0]  win;
    logic            win_found;
    logic            load;
    logic            grant;
    logic            win_lock;
    logic [IDW-1:0]  ptr_next;
    logic [NREQ-1:0] req_ready;
    logic [XW-1:0]   x_sel;
    logic [YW-1:0]   y_sel;
    logic [SW-1:0]   sum;

    always_comb begin
        pick = rr_pick(MaxReq'(bus.req_valid), MaxIdw'(ptr_q), NREQ);
        if (state_q == StLock) begin
            win       = owner_q;
            win_found = bus.req_valid[owner_q];
        end else begin
            win       = IDW'(pick.idx);
            win_found = pick.found;
        end
    end

    assign load     = !res_valid_q || bus.res_ready;
    // Ready is forced low while reset is held, independent of register state.
    assign grant    = rst_ni && load && win_found;
    assign win_lock = bus.req_lock[win];
    assign ptr_next = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;

    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready[win] = 1'b1;
        end
    end

    assign x_sel = bus.req_x[win*XW +: XW];
    assign y_sel = bus.req_y[win*YW +: YW];

    UBKSA_7_0_9_0 u_adder (
        .x_i (x_sel),
        .y_i (y_sel),
        .s_o (sum)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StArb;
            ptr_q       <= '0;
            owner_q     <= '0;
            res_id_q    <= '0;
            res_s_q     <= '0;
            res_valid_q <= 1'b0;
        end else begin
            if (load) begin
                if (grant) begin
                    res_s_q     <= sum;
                    res_id_q    <= win;
                    res_valid_q <= 1'b1;
                    ptr_q       <= ptr_next;
                end else begin
                    res_valid_q <= 1'b0;
                end
            end
            unique case (state_q)
                StArb: begin
                    if (grant && win_lock) begin
                        state_q <= StLock;
                        owner_q <= win;
                    end
                end
                StLock: begin
                    if (grant) begin
                        if (!win_lock) begin
                            state_q <= StArb;
                        end
                    end else if (!bus.req_valid[owner_q] && !bus.req_lock[owner_q]) begin
                        // Owner walked away without a final transfer.
                        state_q <= StArb;
                    end
                end
                default: state_q <= StArb;
            endcase
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.res_valid = res_valid_q;
    assign bus.res_s     = res_s_q;
    assign bus.res_id    = res_id_q;
    assign bus.busy      = (state_q == StLock) || res_valid_q;

endmodule

// File: doc/ksa_share_arbiter.md
# ksa_share_arbiter

Shares one 8-bit + 10-bit Kogge-Stone adder (11-bit unsigned sum, carry-in tied to 0) among NREQ requesters. Each requester has its own valid/ready port. Arbitration is round-robin, with an optional lock that gives one requester back-to-back use. The adder result is registered once, tagged with the requester index, and presented on a single valid/ready result port. The block sits between client engines and the shared adder instance.

## Interface
- NREQ, 4, number of requesters (2..8)
- IDW, $clog2(NREQ), width of the requester index
- CLK  in  1  rising-edge clock
- RSTn  in  1  asynchronous active-low reset
- REQ_VALID  in  NREQ  per-requester operand valid
- REQ_LOCK  in  NREQ  per-requester lock request, sampled with VALID
- REQ_X  in  NREQ*8  operand X; requester i uses bits [8i+7:8i]
- REQ_Y  in  NREQ*10  operand Y; requester i uses bits [10i+9:10i]
- REQ_READY  out  NREQ  per-requester accept; at most one bit high
- RES_VALID  out  1  result register holds data
- RES_READY  in  1  result consumer accepts
- RES_S  out  11  registered X+Y
- RES_ID  out  IDW  index of the requester that owns RES_S
- BUSY  out  1  high when state==LOCK or RES_VALID

## Operation
- LOAD = !RES_VALID || RES_READY. No requester is granted while LOAD=0.
- Winner, ARB state: the first i with REQ_VALID[i]=1, scanning PTR, PTR+1, … mod NREQ.
- Winner, LOCK state: OWNER only, and only if REQ_VALID[OWNER]=1. All other REQ_READY bits are 0.
- REQ_READY[w] = LOAD && a winner w exists. The ready is combinational from VALID, state and RES_READY. REQ_READY must not depend on the requester's own operand values.
- Handshake on requester w (REQ_VALID[w] && REQ_READY[w]) updates the registers:
  - RES_S <= {3'b0,X_w} + {1'b0,Y_w}, range 0..1278, no overflow possible.
  - RES_ID <= w.
  - RES_VALID <= 1.
  - PTR <= (w+1) mod NREQ.
- When LOAD=1 and there is no handshake, RES_VALID <= 0.
- State machine:
  - ARB→LOCK on a handshake with REQ_LOCK[w]=1; OWNER <= w.
  - LOCK→LOCK on an owner handshake with REQ_LOCK=1.
  - LOCK→ARB on an owner handshake with REQ_LOCK=0. That transfer is the last one of the burst.
  - LOCK→ARB when REQ_VALID[OWNER]=0 and REQ_LOCK[OWNER]=0 (abandon). No transfer occurs.
  - While LOCK, the owner may idle with VALID=0 and LOCK=1. The lock is held.
- A requester keeps VALID and its operands stable until READY. The block does not check this.

## Timing
- Reset (RSTn low, asynchronous):
  - RES_VALID=0, RES_S=0, RES_ID=0, BUSY=0.
  - PTR=0, OWNER=0, state=ARB.
  - REQ_READY=0 while RSTn is low.
- After RSTn deasserts, the first grant is possible in that same cycle if VALID is present.
- Latency: the result is visible on RES_S/RES_ID/RES_VALID one cycle after the requester handshake.
- Throughput: one addition per cycle while RES_READY=1 continuously.
- Backpressure: with RES_VALID=1 and RES_READY=0, RES_S and RES_ID hold and every REQ_READY bit is 0.
- Simultaneous events:
  - RES_READY=1 and a new handshake in the same cycle: the register reloads with no bubble.
  - A requester raises VALID in the cycle its previous result drains: it is eligible if it wins.
- Reset mid-burst: the lock and any in-flight result are discarded. There is no partial output.

## Structure
- Shared package ksa_share_pkg holds:
  - XW=8, YW=10, SW=11.
  - State enum {ARB, LOCK}.
  - Function rr_pick(valid, ptr) returning {found, index}.
- One sub-module: the existing combinational Kogge-Stone adder top UBKSA_7_0_9_0.
  - Instanced once.
  - Its inputs are driven from a mux selected by the winner index.
  - RES_S registers its output directly.
- The arbiter, state machine and result register live in ksa_share_arbiter. Budget is about 150–250 lines.

## Test plan
- Single requester, NREQ=4: req0 X=8'hFF, Y=10'h3FF, RES_READY=1 → one cycle later RES_VALID=1, RES_S=11'd1278, RES_ID=0; REQ_READY[0] high in the request cycle.
- All four VALID continuously, no lock, RES_READY=1 → RES_ID sequence 0,1,2,3,0,… with one result per cycle and no bubbles.
- req2 LOCK=1 for three transfers (X=1,2,3; Y=10), with req1 and req3 also valid:
  - Results are 11,12,13, each with RES_ID=2.
  - The third transfer has LOCK=0.
  - The next grant goes to req3 (PTR=3).
- RES_READY=0 for 5 cycles with RES_VALID=1:
  - RES_S and RES_ID are unchanged and REQ_READY=0.
  - On release, the pending result drains and the next grant occurs in the same cycle.
- Lock abandon: req1 gets LOCK=1, then drops VALID and LOCK → the state returns to ARB the next cycle; req0 is then granted.
- RSTn pulse low mid-burst with RES_VALID=1 → outputs go to reset values immediately; after release, req0 wins first (PTR=0).
